// File: rtl/l3_cache_sa.sv
// l3_cache_sa
//   Set-associative, write-back, write-allocate last-level cache sitting
//   between the L2 line interface and the external RAM line interface.
//   One request at a time, true-LRU replacement, dirty victims are written
//   back before refill, and a flush command drains every dirty line.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   re_i / we_i               line read / write request (write wins)
//   addr_i / wdata_i          request byte address / write line
//   rdata_o / done_o          read line / one-cycle completion pulse
//   busy_o                    request or flush in progress
//   flush_i / flush_done_o    flush command / one-cycle completion pulse
//   re_m_o, raddr_m_o         RAM line read request and line address
//   rdata_m_i, read_hit_m_i   RAM read data and ack
//   we_m_o, waddr_m_o,        RAM line write request, line address, data
//   wdata_m_o, write_hit_m_i  and RAM write ack
//   writing_o                 at least one dirty line resident
//   dbg_state_o               current FSM state (debug)
//
// Handshake: upstream presents re_i/we_i/flush_i while busy_o=0 and the
// request is taken on the first rising edge in IDLE; completion is the
// done_o/flush_done_o pulse. Toward RAM, re_m_o/we_m_o act as valid with
// address/data held stable, and read_hit_m_i/write_hit_m_i act as ready:
// the transfer happens on the rising edge where both are high.
module l3_cache_sa #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int SETS   = 256,
  parameter int WAYS   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] wdata_i,
  output logic [LINE_W-1:0] rdata_o,
  output logic              done_o,
  output logic              busy_o,
  input  logic              flush_i,
  output logic              flush_done_o,
  output logic              re_m_o,
  output logic [ADDR_W-1:0] raddr_m_o,
  input  logic [LINE_W-1:0] rdata_m_i,
  input  logic              read_hit_m_i,
  output logic              we_m_o,
  output logic [ADDR_W-1:0] waddr_m_o,
  output logic [LINE_W-1:0] wdata_m_o,
  input  logic              write_hit_m_i,
  output logic              writing_o,
  output logic [2:0]        dbg_state_o
);
  localparam int OFF_W = $clog2(LINE_W/8);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int CNT_W = $clog2(SETS*WAYS) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WB, S_FILL, S_RESP, S_FL_SCAN, S_FL_WB
  } state_t;

  // Line storage
  logic [LINE_W-1:0] data_mem  [SETS][WAYS];
  logic [TAG_W-1:0]  tag_mem   [SETS][WAYS];
  logic [WAY_W-1:0]  age_mem   [SETS][WAYS];
  logic [WAYS-1:0]   valid_mem [SETS];
  logic [WAYS-1:0]   dirty_mem [SETS];

  // Control registers
  state_t                    state_q, state_d;
  logic                      op_we_q, op_we_d;
  logic [ADDR_W-OFF_W-1:0]   line_q, line_d;
  logic [LINE_W-1:0]         wdata_q, wdata_d;
  logic [WAY_W-1:0]          victim_q, victim_d;
  logic [IDX_W-1:0]          scan_set_q, scan_set_d;
  logic [WAY_W-1:0]          scan_way_q, scan_way_d;
  logic [LINE_W-1:0]         rdata_q, rdata_d;
  logic                      flush_done_q, flush_done_d;
  logic                      re_m_q, re_m_d;
  logic                      we_m_q, we_m_d;
  logic [ADDR_W-1:0]         raddr_q, raddr_d;
  logic [ADDR_W-1:0]         waddr_q, waddr_d;
  logic [LINE_W-1:0]         wdata_m_q, wdata_m_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      writing_q, writing_d;

  // Memory write controls, all aimed at one (acc_set, acc_way) per cycle
  logic [IDX_W-1:0]  acc_set;
  logic [WAY_W-1:0]  acc_way;
  logic              data_we, tag_we, dirty_we, dirty_val, lru_we;
  logic [LINE_W-1:0] line_wdata;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             hit, found;
  logic [WAY_W-1:0] hit_way, victim;
  logic             scan_last;

  logic unused_off;
  assign unused_off = ^addr_i[OFF_W-1:0];

  assign req_idx = line_q[IDX_W-1:0];
  assign req_tag = line_q[ADDR_W-OFF_W-1 -: TAG_W];
  assign scan_last = (scan_set_q == IDX_W'(SETS-1)) && (scan_way_q == WAY_W'(WAYS-1));

  // Tag match; at most one way can match, the first one found is used
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_mem[req_idx][w] && (tag_mem[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Victim: lowest invalid way first, otherwise the oldest way
  always_comb begin
    found  = 1'b0;
    victim = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid_mem[req_idx][w]) begin
        found  = 1'b1;
        victim = WAY_W'(w);
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (!found && (age_mem[req_idx][w] == WAY_W'(WAYS-1))) begin
        found  = 1'b1;
        victim = WAY_W'(w);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    op_we_d      = op_we_q;
    line_d       = line_q;
    wdata_d      = wdata_q;
    victim_d     = victim_q;
    scan_set_d   = scan_set_q;
    scan_way_d   = scan_way_q;
    rdata_d      = rdata_q;
    flush_done_d = 1'b0;
    re_m_d       = re_m_q;
    we_m_d       = we_m_q;
    raddr_d      = raddr_q;
    waddr_d      = waddr_q;
    wdata_m_d    = wdata_m_q;
    cnt_d        = cnt_q;
    acc_set      = req_idx;
    acc_way      = victim_q;
    data_we      = 1'b0;
    tag_we       = 1'b0;
    dirty_we     = 1'b0;
    dirty_val    = 1'b0;
    lru_we       = 1'b0;
    line_wdata   = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (we_i || re_i) begin
          op_we_d = we_i;
          line_d  = addr_i[ADDR_W-1:OFF_W];
          wdata_d = wdata_i;
          state_d = S_LOOKUP;
        end else if (flush_i) begin
          scan_set_d = '0;
          scan_way_d = '0;
          state_d    = S_FL_SCAN;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          acc_way = hit_way;
          lru_we  = 1'b1;
          if (op_we_q) begin
            data_we   = 1'b1;
            dirty_we  = 1'b1;
            dirty_val = 1'b1;
            if (!dirty_mem[req_idx][hit_way]) cnt_d = cnt_q + CNT_W'(1);
            rdata_d = '0;
          end else begin
            rdata_d = data_mem[req_idx][hit_way];
          end
          state_d = S_RESP;
        end else begin
          victim_d = victim;
          if (valid_mem[req_idx][victim] && dirty_mem[req_idx][victim]) begin
            we_m_d    = 1'b1;
            waddr_d   = {tag_mem[req_idx][victim], req_idx, {OFF_W{1'b0}}};
            wdata_m_d = data_mem[req_idx][victim];
            state_d   = S_WB;
          end else begin
            re_m_d  = 1'b1;
            raddr_d = {req_tag, req_idx, {OFF_W{1'b0}}};
            state_d = S_FILL;
          end
        end
      end
      S_WB: begin
        if (write_hit_m_i) begin
          we_m_d   = 1'b0;
          dirty_we = 1'b1;
          cnt_d    = cnt_q - CNT_W'(1);
          re_m_d   = 1'b1;
          raddr_d  = {req_tag, req_idx, {OFF_W{1'b0}}};
          state_d  = S_FILL;
        end
      end
      S_FILL: begin
        if (read_hit_m_i) begin
          re_m_d     = 1'b0;
          data_we    = 1'b1;
          tag_we     = 1'b1;
          dirty_we   = 1'b1;
          dirty_val  = op_we_q;
          lru_we     = 1'b1;
          line_wdata = op_we_q ? wdata_q : rdata_m_i;
          rdata_d    = op_we_q ? '0 : rdata_m_i;
          if (op_we_q) cnt_d = cnt_q + CNT_W'(1);
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        rdata_d = '0;
        state_d = S_IDLE;
      end
      S_FL_SCAN: begin
        acc_set = scan_set_q;
        acc_way = scan_way_q;
        if (dirty_mem[scan_set_q][scan_way_q]) begin
          we_m_d    = 1'b1;
          waddr_d   = {tag_mem[scan_set_q][scan_way_q], scan_set_q, {OFF_W{1'b0}}};
          wdata_m_d = data_mem[scan_set_q][scan_way_q];
          state_d   = S_FL_WB;
        end
      end
      S_FL_WB: begin
        acc_set = scan_set_q;
        acc_way = scan_way_q;
        if (write_hit_m_i) begin
          we_m_d   = 1'b0;
          dirty_we = 1'b1;
          cnt_d    = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush walk advances from a clean line in FL_SCAN or a finished
    // writeback in FL_WB.
    if ((state_q == S_FL_SCAN && !dirty_mem[scan_set_q][scan_way_q]) ||
        (state_q == S_FL_WB && write_hit_m_i)) begin
      if (scan_last) begin
        flush_done_d = 1'b1;
        state_d      = S_IDLE;
      end else begin
        state_d = S_FL_SCAN;
        if (scan_way_q == WAY_W'(WAYS-1)) begin
          scan_way_d = '0;
          scan_set_d = scan_set_q + IDX_W'(1);
        end else begin
          scan_way_d = scan_way_q + WAY_W'(1);
        end
      end
    end

    writing_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      op_we_q      <= 1'b0;
      line_q       <= '0;
      wdata_q      <= '0;
      victim_q     <= '0;
      scan_set_q   <= '0;
      scan_way_q   <= '0;
      rdata_q      <= '0;
      flush_done_q <= 1'b0;
      re_m_q       <= 1'b0;
      we_m_q       <= 1'b0;
      raddr_q      <= '0;
      waddr_q      <= '0;
      wdata_m_q    <= '0;
      cnt_q        <= '0;
      writing_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_we_q      <= op_we_d;
      line_q       <= line_d;
      wdata_q      <= wdata_d;
      victim_q     <= victim_d;
      scan_set_q   <= scan_set_d;
      scan_way_q   <= scan_way_d;
      rdata_q      <= rdata_d;
      flush_done_q <= flush_done_d;
      re_m_q       <= re_m_d;
      we_m_q       <= we_m_d;
      raddr_q      <= raddr_d;
      waddr_q      <= waddr_d;
      wdata_m_q    <= wdata_m_d;
      cnt_q        <= cnt_d;
      writing_q    <= writing_d;
    end
  end

  // Valid/dirty/age reset invalidates the cache; ages restart as way index.
  // LRU: touched way becomes 0, every younger way ages by one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_mem[s] <= '0;
        dirty_mem[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_mem[s][w] <= WAY_W'(w);
      end
    end else begin
      if (tag_we)   valid_mem[acc_set][acc_way] <= 1'b1;
      if (dirty_we) dirty_mem[acc_set][acc_way] <= dirty_val;
      if (lru_we) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == acc_way)
            age_mem[acc_set][w] <= '0;
          else if (age_mem[acc_set][w] < age_mem[acc_set][acc_way])
            age_mem[acc_set][w] <= age_mem[acc_set][w] + WAY_W'(1);
        end
      end
    end
  end

  // Data and tags need no reset: valid gates every use.
  always_ff @(posedge clk) begin
    if (data_we) data_mem[acc_set][acc_way] <= line_wdata;
    if (tag_we)  tag_mem[acc_set][acc_way]  <= req_tag;
  end

  assign rdata_o      = rdata_q;
  assign done_o       = (state_q == S_RESP);
  assign busy_o       = (state_q != S_IDLE) && (state_q != S_RESP);
  assign flush_done_o = flush_done_q;
  assign re_m_o       = re_m_q;
  assign raddr_m_o    = raddr_q;
  assign we_m_o       = we_m_q;
  assign waddr_m_o    = waddr_q;
  assign wdata_m_o    = wdata_m_q;
  assign writing_o    = writing_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_l3_cache_sa.sv
// tb_l3_cache_sa
//   Directed bench for l3_cache_sa with default geometry (32-byte lines,
//   256 sets, 4 ways). A behavioural RAM answers line reads/writes after a
//   programmable number of wait cycles and logs every transfer.
module tb_l3_cache_sa;
  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          re_i = 1'b0, we_i = 1'b0, flush_i = 1'b0;
  logic [AW-1:0] addr_i = '0;
  logic [LW-1:0] wdata_i = '0;
  logic [LW-1:0] rdata_o;
  logic          done_o, busy_o, flush_done_o;
  logic          re_m_o, we_m_o;
  logic [AW-1:0] raddr_m_o, waddr_m_o;
  logic [LW-1:0] rdata_m_i = '0;
  logic          read_hit_m_i = 1'b0, write_hit_m_i = 1'b0;
  logic [LW-1:0] wdata_m_o;
  logic          writing_o;
  logic [2:0]    dbg_state;

  l3_cache_sa dut (
    .clk(clk), .rst(rst),
    .re_i(re_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .rdata_o(rdata_o), .done_o(done_o), .busy_o(busy_o),
    .flush_i(flush_i), .flush_done_o(flush_done_o),
    .re_m_o(re_m_o), .raddr_m_o(raddr_m_o),
    .rdata_m_i(rdata_m_i), .read_hit_m_i(read_hit_m_i),
    .we_m_o(we_m_o), .waddr_m_o(waddr_m_o), .wdata_m_o(wdata_m_o),
    .write_hit_m_i(write_hit_m_i), .writing_o(writing_o),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [LW-1:0] ram [logic [AW-1:0]];
  logic [AW-1:0] rd_log[$];
  logic [AW-1:0] wr_addr_q[$];
  logic [LW-1:0] exp_q[$];      // data seen on RAM writes, in order
  int ram_lat  = 2;
  int ram_wait = 0;
  int overlap_cnt = 0;

  function automatic logic [LW-1:0] default_line(input logic [AW-1:0] a);
    return {8{a ^ 32'h5A5A_5A5A}};
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- RAM responder ----------------
  initial begin
    forever begin
      @(negedge clk);
      read_hit_m_i  = 1'b0;
      write_hit_m_i = 1'b0;
      if (re_m_o && we_m_o) overlap_cnt++;
      if (re_m_o || we_m_o) begin
        if (ram_wait < ram_lat) ram_wait++;
        else begin
          ram_wait = 0;
          if (re_m_o) begin
            read_hit_m_i = 1'b1;
            rdata_m_i = ram.exists(raddr_m_o) ? ram[raddr_m_o] : default_line(raddr_m_o);
            rd_log.push_back(raddr_m_o);
          end else begin
            write_hit_m_i = 1'b1;
            ram[waddr_m_o] = wdata_m_o;
            wr_addr_q.push_back(waddr_m_o);
            exp_q.push_back(wdata_m_o);
          end
        end
      end else begin
        ram_wait = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Issues one request and waits for done_o. lat counts negedges after the
  // accepting edge (hit -> 2); -1 on timeout.
  task automatic do_req(input bit we, input logic [AW-1:0] a, input logic [LW-1:0] d,
                        output int lat, output logic [LW-1:0] rd);
    @(negedge clk);
    re_i = !we; we_i = we; addr_i = a; wdata_i = d;
    @(posedge clk);
    @(negedge clk);
    re_i = 1'b0; we_i = 1'b0;
    lat = 1;
    while (!done_o && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    rd = rdata_o;
    if (!done_o) lat = -1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] exp_rdata;
    int            exp_lat;
    int            exp_rd;
    int            exp_wr;
    bit            exp_writing;
  } vec_t;

  vec_t vecs[9];

  localparam logic [LW-1:0] A5 = {32{8'hA5}};
  localparam logic [LW-1:0] D1 = {8{32'hD1D1_0001}};
  localparam logic [LW-1:0] D2 = {8{32'hD2D2_0002}};
  localparam logic [LW-1:0] DA = {8{32'hDADA_000A}};
  localparam logic [LW-1:0] DB = {8{32'hDBDB_000B}};
  localparam logic [LW-1:0] DC = {8{32'hDCDC_000C}};

  initial begin
    int lat;
    int rd0, wr0, cyc;
    logic [LW-1:0] rd;

    vecs[0] = '{1'b0, 32'h0000_1000, '0, A5, 5, 1, 0, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_1000, '0, A5, 2, 0, 0, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_1010, '0, A5, 2, 0, 0, 1'b0};
    vecs[3] = '{1'b1, 32'h0000_2000, D1, '0, 5, 1, 0, 1'b1};
    vecs[4] = '{1'b0, 32'h0000_2000, '0, D1, 2, 0, 0, 1'b1};
    vecs[5] = '{1'b1, 32'h0000_2000, D2, '0, 2, 0, 0, 1'b1};
    vecs[6] = '{1'b0, 32'h0000_2000, '0, D2, 2, 0, 0, 1'b1};
    vecs[7] = '{1'b0, 32'h0000_3000, '0, default_line(32'h3000), 5, 1, 0, 1'b1};
    vecs[8] = '{1'b0, 32'h0000_1000, '0, A5, 2, 0, 0, 1'b1};

    ram[32'h0000_1000] = A5;

    // ---- reset state ----
    do_reset();
    chk("rst_done",    {255'd0, done_o}, '0);
    chk("rst_busy",    {255'd0, busy_o}, '0);
    chk("rst_re_m",    {255'd0, re_m_o}, '0);
    chk("rst_we_m",    {255'd0, we_m_o}, '0);
    chk("rst_writing", {255'd0, writing_o}, '0);
    chk("rst_rdata",   rdata_o, '0);
    chk("rst_addrs",   {raddr_m_o, waddr_m_o}, '0);

    // ---- table-driven sequence ----
    for (int i = 0; i < 9; i++) begin
      rd0 = rd_log.size();
      wr0 = wr_addr_q.size();
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rd);
      chk($sformatf("vec%0d_lat", i),     LW'(lat), LW'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_rdata", i),   rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_ramrd", i),   LW'(rd_log.size() - rd0), LW'(vecs[i].exp_rd));
      chk($sformatf("vec%0d_ramwr", i),   LW'(wr_addr_q.size() - wr0), LW'(vecs[i].exp_wr));
      chk($sformatf("vec%0d_writing", i), {255'd0, writing_o}, {255'd0, vecs[i].exp_writing});
    end
    chk("first_raddr", {224'd0, rd_log[0]}, {224'd0, 32'h0000_1000});

    // ---- dirty victim writeback (set 0, tags 1..5) ----
    do_reset();
    do_req(1'b1, 32'h0000_2000, D1, lat, rd);
    do_req(1'b0, 32'h0000_4000, '0, lat, rd);
    do_req(1'b0, 32'h0000_6000, '0, lat, rd);
    do_req(1'b0, 32'h0000_8000, '0, lat, rd);
    chk("wb_pre_writing", {255'd0, writing_o}, {255'd0, 1'b1});
    wr0 = wr_addr_q.size();
    do_req(1'b0, 32'h0000_A000, '0, lat, rd);
    chk("wb_lat",   LW'(lat), LW'(8));
    chk("wb_rdata", rd, default_line(32'h0000_A000));
    chk("wb_count", LW'(wr_addr_q.size() - wr0), LW'(1));
    if (wr_addr_q.size() > wr0) begin
      chk("wb_addr", {224'd0, wr_addr_q[wr0]}, {224'd0, 32'h0000_2000});
      chk("wb_data", exp_q[wr0], D1);
    end
    chk("wb_writing", {255'd0, writing_o}, '0);
    do_req(1'b0, 32'h0000_2000, '0, lat, rd);
    chk("wb_reload_lat",   LW'(lat), LW'(5));
    chk("wb_reload_rdata", rd, D1);
    do_req(1'b0, 32'h0000_6000, '0, lat, rd);
    chk("wb_keep_hit", LW'(lat), LW'(2));

    // ---- LRU order: ways 0..3, re-touch way 0, miss evicts way 1 ----
    do_reset();
    do_req(1'b0, 32'h0000_2000, '0, lat, rd);
    do_req(1'b0, 32'h0000_4000, '0, lat, rd);
    do_req(1'b0, 32'h0000_6000, '0, lat, rd);
    do_req(1'b0, 32'h0000_8000, '0, lat, rd);
    do_req(1'b0, 32'h0000_2000, '0, lat, rd);
    chk("lru_retouch_hit", LW'(lat), LW'(2));
    do_req(1'b0, 32'h0000_A000, '0, lat, rd);
    chk("lru_miss_lat", LW'(lat), LW'(5));
    do_req(1'b0, 32'h0000_2000, '0, lat, rd);
    chk("lru_way0_kept", LW'(lat), LW'(2));
    do_req(1'b0, 32'h0000_6000, '0, lat, rd);
    chk("lru_way2_kept", LW'(lat), LW'(2));
    do_req(1'b0, 32'h0000_8000, '0, lat, rd);
    chk("lru_way3_kept", LW'(lat), LW'(2));
    do_req(1'b0, 32'h0000_4000, '0, lat, rd);
    chk("lru_way1_evicted", LW'(lat), LW'(5));

    // ---- flush: three dirty lines drained in index/way order ----
    do_reset();
    do_req(1'b1, 32'h0000_0040, DA, lat, rd);
    do_req(1'b1, 32'h0000_4020, DB, lat, rd);
    do_req(1'b1, 32'h0000_2000, DC, lat, rd);
    do_req(1'b0, 32'h0000_8000, '0, lat, rd);
    chk("fl_pre_writing", {255'd0, writing_o}, {255'd0, 1'b1});
    wr0 = wr_addr_q.size();
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush_i = 1'b0;
    chk("fl_busy", {255'd0, busy_o}, {255'd0, 1'b1});
    cyc = 0;
    while (!flush_done_o && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    chk("fl_done_seen", {255'd0, flush_done_o}, {255'd0, 1'b1});
    @(negedge clk);
    chk("fl_done_pulse", {255'd0, flush_done_o}, '0);
    chk("fl_count", LW'(wr_addr_q.size() - wr0), LW'(3));
    if (wr_addr_q.size() >= wr0 + 3) begin
      chk("fl_addr0", {224'd0, wr_addr_q[wr0]},   {224'd0, 32'h0000_2000});
      chk("fl_addr1", {224'd0, wr_addr_q[wr0+1]}, {224'd0, 32'h0000_4020});
      chk("fl_addr2", {224'd0, wr_addr_q[wr0+2]}, {224'd0, 32'h0000_0040});
      chk("fl_data0", exp_q[wr0],   DC);
      chk("fl_data1", exp_q[wr0+1], DB);
      chk("fl_data2", exp_q[wr0+2], DA);
    end
    chk("fl_writing", {255'd0, writing_o}, '0);
    do_req(1'b0, 32'h0000_2000, '0, lat, rd);
    chk("fl_hit0_lat", LW'(lat), LW'(2));
    chk("fl_hit0_data", rd, DC);
    do_req(1'b0, 32'h0000_0040, '0, lat, rd);
    chk("fl_hit1_lat", LW'(lat), LW'(2));
    chk("fl_hit1_data", rd, DA);

    // ---- reset during FILL ----
    do_reset();
    do_req(1'b0, 32'h0000_1000, '0, lat, rd);
    do_req(1'b0, 32'h0000_1000, '0, lat, rd);
    chk("mid_prehit", LW'(lat), LW'(2));
    do_req(1'b1, 32'h0000_5000, D1, lat, rd);
    ram_lat = 60;
    @(negedge clk);
    re_i = 1'b1; addr_i = 32'h0000_3000;
    @(posedge clk);
    @(negedge clk);
    re_i = 1'b0;
    @(negedge clk);
    chk("mid_re_m_high", {255'd0, re_m_o}, {255'd0, 1'b1});
    chk("mid_raddr", {224'd0, raddr_m_o}, {224'd0, 32'h0000_3000});
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_re_m",    {255'd0, re_m_o}, '0);
    chk("mid_rst_busy",    {255'd0, busy_o}, '0);
    chk("mid_rst_raddr",   {224'd0, raddr_m_o}, '0);
    chk("mid_rst_writing", {255'd0, writing_o}, '0);
    chk("mid_rst_state",   {253'd0, dbg_state}, '0);
    @(negedge clk);
    rst = 1'b1;
    ram_lat = 2;
    repeat (2) @(negedge clk);
    do_req(1'b0, 32'h0000_1000, '0, lat, rd);
    chk("mid_post_miss", LW'(lat), LW'(5));
    chk("mid_post_rdata", rd, A5);

    chk("no_re_we_overlap", LW'(overlap_cnt), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/l3_cache_sa.md
# l3_cache_sa

Parametrised set-associative, write-back, write-allocate last-level cache between the L2 line interface and the external RAM line interface. Successor to the fixed 4-way/256-set L3: geometry is generic, replacement is true LRU, dirty victims are written back before refill, and a flush command drains all dirty lines. It services one request at a time through a single-issue FSM.

## Interface
- ADDR_W, 32, byte address width
- LINE_W, 256, line width in bits (power of 2, ≥64); OFF_W = log2(LINE_W/8)
- SETS, 256, number of sets (power of 2); IDX_W = log2(SETS)
- WAYS, 4, associativity (power of 2, 1..8); TAG_W = ADDR_W-IDX_W-OFF_W
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- re_i  in  1  line read request (sampled only when busy_o=0)
- we_i  in  1  line write request (priority over re_i if both high)
- addr_i  in  ADDR_W  request address; offset bits ignored
- wdata_i  in  LINE_W  write line
- rdata_o  out  LINE_W  read line, valid while done_o=1
- done_o  out  1  one-cycle completion pulse
- busy_o  out  1  request/flush in progress
- flush_i  in  1  flush command (sampled only when busy_o=0 and no re_i/we_i)
- flush_done_o  out  1  one-cycle pulse at flush completion
- re_m_o / raddr_m_o  out  1 / ADDR_W  RAM line read, address offset bits zero
- rdata_m_i / read_hit_m_i  in  LINE_W / 1  RAM read data / ack
- we_m_o / waddr_m_o / wdata_m_o  out  1 / ADDR_W / LINE_W  RAM line write
- write_hit_m_i  in  1  RAM write ack
- writing_o  out  1  at least one dirty line resident

## Operation
- Per line: data, tag, valid, dirty, age (log2(WAYS) bits). Reset: valid=dirty=0, age[w]=w.
- States: IDLE, LOOKUP, WB, FILL, RESP, FL_SCAN, FL_WB.
- IDLE: on accepted request, register op/addr/wdata, busy_o=1 next cycle, go LOOKUP.
- LOOKUP: hit = valid && tag match in any way.
  - Read hit: rdata_o=line, update LRU -> RESP.
  - Write hit: line<=wdata, dirty<=1, update LRU -> RESP.
  - Miss: victim = lowest-index invalid way, else way with age=WAYS-1. Victim dirty -> WB, else FILL.
- WB: we_m_o=1, waddr_m_o={victim tag, idx, 0}, wdata_m_o=victim data; held until write_hit_m_i=1; that edge clears we_m_o and victim dirty -> FILL.
- FILL: re_m_o=1, raddr_m_o={tag, idx, 0} held until read_hit_m_i=1; that edge installs line (valid=1, tag), dirty=0 for read, for write install wdata with dirty=1; rdata_o=rdata_m_i for read; update LRU -> RESP.
- RESP: done_o=1 one cycle, busy_o=0 same cycle -> IDLE. For writes rdata_o=0.
- LRU update on way k with old age a: age[k]<=0; every way with age<a increments; others unchanged. Ages in a set always a permutation of 0..WAYS-1.
- Flush: FL_SCAN walks index 0..SETS-1, way 0..WAYS-1 in order, one line per cycle; dirty line -> FL_WB (same handshake as WB), clear dirty, resume at next line. After last line: flush_done_o=1 one cycle, -> IDLE. Valid and LRU untouched.
- writing_o from a dirty counter (width log2(SETS*WAYS)+1): +1 on clean->dirty, -1 on writeback; writing_o = counter!=0, registered.
- RAM acks ignored outside WB/FILL/FL_WB.

## Timing
- Reset values: rdata_o=0, done_o=0, busy_o=0, flush_done_o=0, re_m_o=0, we_m_o=0, raddr_m_o=0, waddr_m_o=0, wdata_m_o=0, writing_o=0, FSM=IDLE.
- Hit latency: request edge N -> done_o high in cycle N+2.
- Clean miss: re_m_o high from cycle N+2; ack at edge M -> done_o in cycle M+1.
- Dirty miss: we_m_o from N+2; write ack edge W -> re_m_o from W+1; read ack edge M -> done_o M+1.
- re_m_o and we_m_o never high together; address/data stable while request high.
- Requests while busy_o=1 ignored (no queueing); upstream holds until done_o.
- Ack in same cycle request raises: accepted on that edge.
- rst low mid-operation: immediate return to reset state, pending RAM request dropped, cache contents invalidated.

## Test plan
- Reset, read 0x0000_1000 (miss), RAM returns 0xA5.. -> re_m_o raddr=0x1000, done_o with rdata=0xA5..; repeat read -> hit, done 2 cycles after request, no RAM traffic.
- Write 0x2000 data D1 (write-allocate), then read 0x2000 -> RAM read once, rdata=D1, writing_o=1.
- Defaults: fill 5 tags into set 0 after dirtying the first -> 5th access writes back tag0 line (waddr=tag0 address, data correct) before refill; victim is LRU way.
- LRU order: access ways 0,1,2,3, re-touch 0, miss -> way 1 evicted.
- Three dirty lines, flush_i -> three RAM writes in index/way order, flush_done_o pulse, writing_o=0, subsequent reads hit.
- Assert rst during FILL with re_m_o high -> all outputs zero asynchronously, prior hit address now misses.
